biriscv_pipe_ctrl_nstage: RTL and testbench

Parametrised in-order execution-pipeline controller with NUM_STAGES execute stages followed by a commit (WB) register. It tracks per-stage valid, control, rd, PC and result, and generates the stall, squash and writeback controls. It adds timing-error replay, which the fixed two-stage controller does not have. When timing_error_i flags a suspect result in the last execute stage, that instruction is dropped, all stages are flushed, and a replay PC is returned to the frontend. Issue is then held off for a guard gap.

---
 rtl/biriscv_pipe_ctrl_nstage_pkg.sv | 30 +++
 rtl/biriscv_pipe_ctrl_nstage_stage_reg.sv | 25 ++
 rtl/biriscv_pipe_ctrl_nstage.sv | 207 ++++++++++++++++++++
 tb/tb_biriscv_pipe_ctrl_nstage.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_pipe_ctrl_nstage_pkg.sv
// Shared types for the N-stage execute pipeline controller.
// Holds the FSM encoding, the per-stage bundle and small helpers.
package biriscv_pipe_ctrl_nstage_pkg;

    localparam int PIPE_XLEN  = 32;
    localparam int PIPE_EXC_W = 6;

    localparam logic [PIPE_EXC_W-1:0] EXC_NONE = '0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic                  lsu;
        logic                  rd_valid;
        logic [4:0]            rd;
        logic [PIPE_XLEN-1:0]  pc;
        logic [PIPE_EXC_W-1:0] exc;
        logic [PIPE_XLEN-1:0]  result;
    } stage_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/biriscv_pipe_ctrl_nstage_stage_reg.sv
// One execute-stage register of the pipeline controller.
// A flush clears the stage even while the pipe is frozen.
module biriscv_pipe_stage_reg
    import biriscv_pipe_ctrl_nstage_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  logic   invalidate,
    input  stage_t load,
    output stage_t q
);

    // Invalidate wins over hold; otherwise load unless frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (invalidate) begin
            q <= '0;
        end else if (!hold) begin
            q <= load;
        end
    end

endmodule

// File: rtl/biriscv_pipe_ctrl_nstage.sv
// In-order N-stage execute controller with commit register.
// Adds timing-error replay with a guard gap and a fatal limit.
module biriscv_pipe_ctrl_nstage
    import biriscv_pipe_ctrl_nstage_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int XLEN       = PIPE_XLEN,
    parameter int EXC_W      = PIPE_EXC_W,
    parameter int REPLAY_GAP = 2,
    parameter int MAX_REPLAY = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    issue_valid_i,
    input  logic                    issue_lsu_i,
    input  logic                    issue_rd_valid_i,
    input  logic [4:0]              issue_rd_i,
    input  logic [XLEN-1:0]         issue_pc_i,
    input  logic [EXC_W-1:0]        issue_exception_i,
    input  logic [XLEN-1:0]         result_e1_i,
    input  logic                    late_valid_i,
    input  logic [XLEN-1:0]         late_result_i,
    input  logic                    mem_complete_i,
    input  logic                    timing_error_i,
    input  logic                    squash_i,
    output logic                    issue_accept_o,
    output logic                    stall_o,
    output logic [NUM_STAGES-1:0]   stage_valid_o,
    output logic [5*NUM_STAGES-1:0] stage_rd_o,
    output logic                    valid_wb_o,
    output logic [4:0]              rd_wb_o,
    output logic [XLEN-1:0]         result_wb_o,
    output logic [XLEN-1:0]         pc_wb_o,
    output logic [EXC_W-1:0]        exception_wb_o,
    output logic                    replay_valid_o,
    output logic [XLEN-1:0]         replay_pc_o,
    output logic                    replay_fatal_o
);

    localparam int         LAST     = NUM_STAGES - 1;
    localparam logic [3:0] GAP_LOAD = 4'(REPLAY_GAP);
    localparam logic [3:0] MAX_CNT  = 4'(MAX_REPLAY);

    stage_t          st_q [NUM_STAGES];
    stage_t          st_d [NUM_STAGES];
    stage_t          last;
    state_t          state_q, state_d;
    logic [3:0]      gap_q, gap_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            fatal_q, fatal_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic            stall;
    logic            take_replay;
    logic            take_exc;
    logic            commit;
    logic            kill;
    logic            accept;

    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_result;
    logic [XLEN-1:0]  wb_pc;
    logic [EXC_W-1:0] wb_exc;

    assign last  = st_q[LAST];
    assign stall = last.valid & last.lsu & ~mem_complete_i;

    assign take_replay = (state_q == ST_RUN) & last.valid
                       & ~stall & timing_error_i;
    assign take_exc    = last.valid & ~stall & ~take_replay
                       & (last.exc != EXC_NONE);
    assign commit      = last.valid & ~stall & ~take_replay;
    assign kill        = take_replay | take_exc | squash_i;

    assign accept = issue_valid_i & (state_q == ST_RUN)
                  & ~stall & ~squash_i;

    // Next stage contents: new issue into stage 1, shift the rest.
    always_comb begin
        st_d[0] = '0;
        if (accept) begin
            st_d[0].valid    = 1'b1;
            st_d[0].lsu      = issue_lsu_i;
            st_d[0].rd_valid = issue_rd_valid_i;
            st_d[0].rd       = issue_rd_i;
            st_d[0].pc       = issue_pc_i;
            st_d[0].exc      = issue_exception_i;
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            st_d[k] = st_q[k-1];
        end
        st_d[1].result = result_e1_i;
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        biriscv_pipe_stage_reg u_reg (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .hold       (stall),
            .invalidate (kill),
            .load       (st_d[g]),
            .q          (st_q[g])
        );
    end

    // Commit register; frozen with the stages during an LSU stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_result <= '0;
            wb_pc     <= '0;
            wb_exc    <= '0;
        end else if (!stall) begin
            if (commit) begin
                wb_valid  <= 1'b1;
                wb_pc     <= last.pc;
                wb_exc    <= last.exc;
                wb_result <= late_valid_i ? late_result_i
                                          : last.result;
                wb_rd     <= (last.rd_valid && last.exc == EXC_NONE)
                           ? last.rd : 5'd0;
            end else begin
                wb_valid  <= 1'b0;
                wb_rd     <= '0;
                wb_result <= '0;
                wb_pc     <= '0;
                wb_exc    <= '0;
            end
        end
    end

    // Replay FSM state, gap timer, counter and sticky fatal flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            gap_q   <= '0;
            cnt_q   <= '0;
            fatal_q <= 1'b0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            fatal_q <= fatal_d;
            rpc_q   <= rpc_d;
        end
    end

    // Replay sequencing: RUN -> FLUSH (one cycle) -> GAP -> RUN.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        fatal_d = fatal_q;
        rpc_d   = rpc_q;
        unique case (state_q)
            ST_RUN: begin
                if (take_replay) begin
                    state_d = ST_FLUSH;
                    rpc_d   = last.pc;
                end else if (commit) begin
                    cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                state_d = ST_GAP;
                gap_d   = GAP_LOAD;
                cnt_d   = sat_inc4(cnt_q);
                if (cnt_d >= MAX_CNT) begin
                    fatal_d = 1'b1;
                end
            end
            ST_GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q <= 4'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Per-stage valid and forwarding destination.
    always_comb begin
        stage_valid_o = '0;
        stage_rd_o    = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_valid_o[k] = st_q[k].valid;
            if (st_q[k].valid && st_q[k].rd_valid) begin
                stage_rd_o[k*5 +: 5] = st_q[k].rd;
            end
        end
    end

    assign issue_accept_o = accept;
    assign stall_o        = stall;
    assign valid_wb_o     = wb_valid;
    assign rd_wb_o        = wb_rd;
    assign result_wb_o    = wb_result;
    assign pc_wb_o        = wb_pc;
    assign exception_wb_o = wb_exc;
    assign replay_valid_o = (state_q == ST_FLUSH);
    assign replay_pc_o    = replay_valid_o ? rpc_q : '0;
    assign replay_fatal_o = fatal_q;

endmodule

// File: tb/tb_biriscv_pipe_ctrl_nstage.sv
// Directed bench for the N-stage pipeline controller.
// Three execute stages, replay gap 2, replay limit 3.
module tb_biriscv_pipe_ctrl_nstage;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          issue_valid_i = 1'b0;
    logic          issue_lsu_i = 1'b0;
    logic          issue_rd_valid_i = 1'b0;
    logic [4:0]    issue_rd_i = '0;
    logic [31:0]   issue_pc_i = '0;
    logic [5:0]    issue_exception_i = '0;
    logic [31:0]   result_e1_i = '0;
    logic          late_valid_i = 1'b0;
    logic [31:0]   late_result_i = '0;
    logic          mem_complete_i = 1'b0;
    logic          timing_error_i = 1'b0;
    logic          squash_i = 1'b0;
    logic          issue_accept_o;
    logic          stall_o;
    logic [N-1:0]  stage_valid_o;
    logic [5*N-1:0] stage_rd_o;
    logic          valid_wb_o;
    logic [4:0]    rd_wb_o;
    logic [31:0]   result_wb_o;
    logic [31:0]   pc_wb_o;
    logic [5:0]    exception_wb_o;
    logic          replay_valid_o;
    logic [31:0]   replay_pc_o;
    logic          replay_fatal_o;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    biriscv_pipe_ctrl_nstage #(
        .NUM_STAGES (N),
        .XLEN       (32),
        .EXC_W      (6),
        .REPLAY_GAP (2),
        .MAX_REPLAY (3)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .issue_valid_i     (issue_valid_i),
        .issue_lsu_i       (issue_lsu_i),
        .issue_rd_valid_i  (issue_rd_valid_i),
        .issue_rd_i        (issue_rd_i),
        .issue_pc_i        (issue_pc_i),
        .issue_exception_i (issue_exception_i),
        .result_e1_i       (result_e1_i),
        .late_valid_i      (late_valid_i),
        .late_result_i     (late_result_i),
        .mem_complete_i    (mem_complete_i),
        .timing_error_i    (timing_error_i),
        .squash_i          (squash_i),
        .issue_accept_o    (issue_accept_o),
        .stall_o           (stall_o),
        .stage_valid_o     (stage_valid_o),
        .stage_rd_o        (stage_rd_o),
        .valid_wb_o        (valid_wb_o),
        .rd_wb_o           (rd_wb_o),
        .result_wb_o       (result_wb_o),
        .pc_wb_o           (pc_wb_o),
        .exception_wb_o    (exception_wb_o),
        .replay_valid_o    (replay_valid_o),
        .replay_pc_o       (replay_pc_o),
        .replay_fatal_o    (replay_fatal_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [31:0] pc,
                             input logic [4:0] rd,
                             input logic lsu,
                             input logic [5:0] exc);
        issue_valid_i     = 1'b1;
        issue_lsu_i       = lsu;
        issue_rd_valid_i  = (rd != 5'd0);
        issue_rd_i        = rd;
        issue_pc_i        = pc;
        issue_exception_i = exc;
    endtask

    task automatic idle();
        issue_valid_i     = 1'b0;
        issue_lsu_i       = 1'b0;
        issue_rd_valid_i  = 1'b0;
        issue_rd_i        = '0;
        issue_pc_i        = '0;
        issue_exception_i = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
    endtask

    // Issue one ALU op, walk it to stage 3, raise a timing error;
    // returns with the controller in FLUSH.
    task automatic replay_once(input logic [31:0] pc);
        set_issue(pc, 5'd1, 1'b0, 6'd0);
        step();
        idle();
        step();
        step();
        timing_error_i = 1'b1;
        step();
        timing_error_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        step();
        tests++;
        if (valid_wb_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid_wb: got %0h want 0", valid_wb_o);
        end
        tests++;
        if (stage_valid_o !== 3'b000) begin
            errors++;
            $display("FAIL rst_stage_valid: got %0h want 0", stage_valid_o);
        end
        tests++;
        if (replay_valid_o !== 1'b0 || replay_fatal_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_replay: got %0h/%0h want 0/0",
                     replay_valid_o, replay_fatal_o);
        end
        tests++;
        if (stall_o !== 1'b0 || pc_wb_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_stall_pc: got %0h/%0h want 0/0",
                     stall_o, pc_wb_o);
        end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        set_issue(32'h100, 5'd1, 1'b0, 6'd0);
        #1;
        tests++;
        if (issue_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got %0h want 1", issue_accept_o);
        end
        step();
        set_issue(32'h104, 5'd2, 1'b0, 6'd0);
        result_e1_i = 32'hA1;
        tests++;
        if (stage_rd_o !== 15'h0001) begin
            errors++;
            $display("FAIL b2b_rd_c1: got %0h want 1", stage_rd_o);
        end
        step();
        set_issue(32'h108, 5'd3, 1'b0, 6'd0);
        result_e1_i = 32'hB2;
        tests++;
        if (stage_rd_o !== 15'h0022) begin
            errors++;
            $display("FAIL b2b_rd_c2: got %0h want 22", stage_rd_o);
        end
        step();
        idle();
        result_e1_i = 32'hC3;
        tests++;
        if (stage_rd_o !== 15'h0443 || valid_wb_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rd_c3: got %0h/%0h want 443/0",
                     stage_rd_o, valid_wb_o);
        end
        step();
        tests++;
        if (valid_wb_o !== 1'b1 || pc_wb_o !== 32'h100 ||
            rd_wb_o !== 5'd1 || result_wb_o !== 32'hA1) begin
            errors++;
            $display("FAIL b2b_wb_a: got %0h %0h %0h %0h want 1 100 1 a1",
                     valid_wb_o, pc_wb_o, rd_wb_o, result_wb_o);
        end
        tests++;
        if (stage_rd_o !== 15'h0860) begin
            errors++;
            $display("FAIL b2b_rd_c4: got %0h want 860", stage_rd_o);
        end
        step();
        tests++;
        if (valid_wb_o !== 1'b1 || pc_wb_o !== 32'h104 ||
            rd_wb_o !== 5'd2 || result_wb_o !== 32'hB2) begin
            errors++;
            $display("FAIL b2b_wb_b: got %0h %0h %0h %0h want 1 104 2 b2",
                     valid_wb_o, pc_wb_o, rd_wb_o, result_wb_o);
        end
        step();
        tests++;
        if (valid_wb_o !== 1'b1 || pc_wb_o !== 32'h108 ||
            rd_wb_o !== 5'd3 || result_wb_o !== 32'hC3) begin
            errors++;
            $display("FAIL b2b_wb_c: got %0h %0h %0h %0h want 1 108 3 c3",
                     valid_wb_o, pc_wb_o, rd_wb_o, result_wb_o);
        end
        step();
        tests++;
        if (valid_wb_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wb_end: got %0h want 0", valid_wb_o);
        end
    endtask

    task automatic test_lsu_stall();
        set_issue(32'h2FC, 5'd4, 1'b0, 6'd0);
        step();
        set_issue(32'h300, 5'd5, 1'b1, 6'd0);
        result_e1_i = 32'h58;
        step();
        idle();
        result_e1_i = 32'h11;
        step();
        step();
        tests++;
        if (stall_o !== 1'b1 || valid_wb_o !== 1'b1 ||
            pc_wb_o !== 32'h2FC || result_wb_o !== 32'h58) begin
            errors++;
            $display("FAIL lsu_stall1: got %0h %0h %0h %0h want 1 1 2fc 58",
                     stall_o, valid_wb_o, pc_wb_o, result_wb_o);
        end
        step();
        tests++;
        if (stall_o !== 1'b1 || valid_wb_o !== 1'b1 ||
            pc_wb_o !== 32'h2FC || stage_valid_o !== 3'b100) begin
            errors++;
            $display("FAIL lsu_stall2: got %0h %0h %0h %0h want 1 1 2fc 4",
                     stall_o, valid_wb_o, pc_wb_o, stage_valid_o);
        end
        mem_complete_i = 1'b1;
        late_valid_i   = 1'b1;
        late_result_i  = 32'hDEAD;
        #1;
        tests++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL lsu_release: got %0h want 0", stall_o);
        end
        step();
        mem_complete_i = 1'b0;
        late_valid_i   = 1'b0;
        late_result_i  = '0;
        tests++;
        if (valid_wb_o !== 1'b1 || pc_wb_o !== 32'h300 ||
            rd_wb_o !== 5'd5 || result_wb_o !== 32'hDEAD) begin
            errors++;
            $display("FAIL lsu_commit: got %0h %0h %0h %0h want 1 300 5 dead",
                     valid_wb_o, pc_wb_o, rd_wb_o, result_wb_o);
        end
    endtask

    task automatic test_timing_replay();
        replay_once(32'h200);
        tests++;
        if (valid_wb_o !== 1'b0) begin
            errors++;
            $display("FAIL tr_no_commit: got %0h want 0", valid_wb_o);
        end
        tests++;
        if (replay_valid_o !== 1'b1 || replay_pc_o !== 32'h200) begin
            errors++;
            $display("FAIL tr_replay: got %0h/%0h want 1/200",
                     replay_valid_o, replay_pc_o);
        end
        set_issue(32'h210, 5'd1, 1'b0, 6'd0);
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (issue_accept_o !== 1'b0) begin
                errors++;
                $display("FAIL tr_blocked%0d: got %0h want 0",
                         i, issue_accept_o);
            end
            step();
        end
        tests++;
        if (issue_accept_o !== 1'b1 || replay_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL tr_reopen: got %0h/%0h want 1/0",
                     issue_accept_o, replay_valid_o);
        end
        idle();
    endtask

    task automatic test_replay_fatal();
        do_reset();
        replay_once(32'h600);
        step();
        step();
        step();
        tests++;
        if (replay_fatal_o !== 1'b0) begin
            errors++;
            $display("FAIL fat_after1: got %0h want 0", replay_fatal_o);
        end
        replay_once(32'h604);
        step();
        step();
        step();
        tests++;
        if (replay_fatal_o !== 1'b0) begin
            errors++;
            $display("FAIL fat_after2: got %0h want 0", replay_fatal_o);
        end
        replay_once(32'h608);
        tests++;
        if (replay_valid_o !== 1'b1 || replay_fatal_o !== 1'b0) begin
            errors++;
            $display("FAIL fat_flush3: got %0h/%0h want 1/0",
                     replay_valid_o, replay_fatal_o);
        end
        step();
        tests++;
        if (replay_fatal_o !== 1'b1) begin
            errors++;
            $display("FAIL fat_set: got %0h want 1", replay_fatal_o);
        end
        step();
        step();
        set_issue(32'h60C, 5'd2, 1'b0, 6'd0);
        step();
        idle();
        step();
        step();
        step();
        tests++;
        if (valid_wb_o !== 1'b1 || replay_fatal_o !== 1'b1) begin
            errors++;
            $display("FAIL fat_sticky: got %0h/%0h want 1/1",
                     valid_wb_o, replay_fatal_o);
        end
    endtask

    task automatic test_reset_in_gap();
        replay_once(32'h700);
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        tests++;
        if (replay_fatal_o !== 1'b0 || replay_valid_o !== 1'b0 ||
            replay_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL rg_replay: got %0h %0h %0h want 0 0 0",
                     replay_fatal_o, replay_valid_o, replay_pc_o);
        end
        tests++;
        if (valid_wb_o !== 1'b0 || stage_valid_o !== 3'b000 ||
            pc_wb_o !== 32'h0) begin
            errors++;
            $display("FAIL rg_pipe: got %0h %0h %0h want 0 0 0",
                     valid_wb_o, stage_valid_o, pc_wb_o);
        end
        step();
        rst_ni = 1'b1;
        set_issue(32'h710, 5'd1, 1'b0, 6'd0);
        #1;
        tests++;
        if (issue_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL rg_run: got %0h want 1", issue_accept_o);
        end
        idle();
        step();
    endtask

    task automatic test_exception();
        do_reset();
        set_issue(32'h400, 5'd7, 1'b0, 6'd5);
        step();
        idle();
        step();
        step();
        timing_error_i = 1'b1;
        step();
        timing_error_i = 1'b0;
        tests++;
        if (valid_wb_o !== 1'b0 || exception_wb_o !== 6'd0) begin
            errors++;
            $display("FAIL ex_te_wb: got %0h/%0h want 0/0",
                     valid_wb_o, exception_wb_o);
        end
        tests++;
        if (replay_valid_o !== 1'b1 || replay_pc_o !== 32'h400) begin
            errors++;
            $display("FAIL ex_te_replay: got %0h/%0h want 1/400",
                     replay_valid_o, replay_pc_o);
        end
        step();
        step();
        step();
        set_issue(32'h400, 5'd7, 1'b0, 6'd5);
        step();
        set_issue(32'h404, 5'd8, 1'b0, 6'd0);
        step();
        idle();
        step();
        tests++;
        if (stage_valid_o !== 3'b110) begin
            errors++;
            $display("FAIL ex_pre: got %0h want 6", stage_valid_o);
        end
        step();
        tests++;
        if (valid_wb_o !== 1'b1 || exception_wb_o !== 6'd5 ||
            rd_wb_o !== 5'd0 || pc_wb_o !== 32'h400) begin
            errors++;
            $display("FAIL ex_commit: got %0h %0h %0h %0h want 1 5 0 400",
                     valid_wb_o, exception_wb_o, rd_wb_o, pc_wb_o);
        end
        tests++;
        if (stage_valid_o !== 3'b000) begin
            errors++;
            $display("FAIL ex_flush: got %0h want 0", stage_valid_o);
        end
    endtask

    task automatic test_squash();
        set_issue(32'h500, 5'd9, 1'b0, 6'd0);
        step();
        set_issue(32'h504, 5'd10, 1'b0, 6'd0);
        step();
        set_issue(32'h508, 5'd11, 1'b0, 6'd0);
        squash_i = 1'b1;
        #1;
        tests++;
        if (issue_accept_o !== 1'b0) begin
            errors++;
            $display("FAIL sq_accept: got %0h want 0", issue_accept_o);
        end
        step();
        squash_i = 1'b0;
        idle();
        tests++;
        if (stage_valid_o !== 3'b000 || stage_rd_o !== 15'h0) begin
            errors++;
            $display("FAIL sq_stages: got %0h/%0h want 0/0",
                     stage_valid_o, stage_rd_o);
        end
        step();
        tests++;
        if (valid_wb_o !== 1'b0) begin
            errors++;
            $display("FAIL sq_wb: got %0h want 0", valid_wb_o);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_lsu_stall();
        test_timing_replay();
        test_replay_fatal();
        test_reset_in_gap();
        test_exception();
        test_squash();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
